// File: rtl/wbuf_pkg.sv
// Shared types for the posted-write buffer: FSM states and the buffer entry layout.
package wbuf_pkg;

    localparam int WBUF_ADDR_W = 32;
    localparam int WBUF_DATA_W = 32;
    localparam int WBUF_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE,
        MRD,
        MWR,
        RESP
    } wbuf_state_e;

    typedef struct packed {
        logic                   valid;
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/write_buffer_if.sv
// Cache-side and memory-side signals of the write buffer; slave = buffer, master = environment.
interface write_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] c_addr;
    logic                  c_rd;
    logic                  c_wr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [DATA_WIDTH-1:0] c_rdata;
    logic                  c_ready;

    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_rd;
    logic                  m_wr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_ready;

    logic [CNT_W-1:0]      wb_count;
    logic                  wb_full;

    modport slave (
        input  c_addr, c_rd, c_wr, c_wdata, m_rdata, m_ready,
        output c_rdata, c_ready, m_addr, m_rd, m_wr, m_wdata, wb_count, wb_full
    );

    modport master (
        output c_addr, c_rd, c_wr, c_wdata, m_rdata, m_ready,
        input  c_rdata, c_ready, m_addr, m_rd, m_wr, m_wdata, wb_count, wb_full
    );

endinterface

// File: rtl/wbuf_entry_array.sv
// Circular entry store for the write buffer with a youngest-first address match.
module wbuf_entry_array
    import wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    logic [DEPTH-1:0]      valid;
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      hit_idx;

    // Scan oldest to youngest so the last match (closest to the tail) wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[rd_ptr + PTR_W'(k)] && (addr_mem[rd_ptr + PTR_W'(k)] == req_addr)) begin
                hit     = 1'b1;
                hit_idx = rd_ptr + PTR_W'(k);
            end
        end
    end

    assign hit_data  = data_mem[hit_idx];
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
                count         <= count + CNT_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
                count         <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage carries no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= req_addr;
            data_mem[wr_ptr] <= wr_data;
        end else if (update) begin
            data_mem[hit_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between a cache and backing memory with read forwarding.
// Define WBUF_COALESCE_EN to merge writes to an already-buffered address in place.
module write_buffer
    import wbuf_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst,
    write_buffer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_e           state;
    logic                  push;
    logic                  pop;
    logic                  update;
    logic                  hit;
    logic                  full;
    logic                  accept_wr;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CNT_W-1:0]      count;

    wbuf_entry_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_entries (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .update    (update),
        .req_addr  (bus.c_addr),
        .wr_data   (bus.c_wdata),
        .hit       (hit),
        .hit_data  (hit_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .full      (full)
    );

    // A simultaneous read suppresses the write; a write blocked by a full buffer falls through to a drain.
    always_comb begin
        push   = 1'b0;
        update = 1'b0;
        if ((state == IDLE) && bus.c_wr && !bus.c_rd) begin
`ifdef WBUF_COALESCE_EN
            if (hit) begin
                update = 1'b1;
            end else begin
                push = !full;
            end
`else
            push = !full;
`endif
        end
    end

    assign accept_wr    = push | update;
    assign pop          = (state == MWR) && bus.m_ready;
    assign bus.wb_count = count;
    assign bus.wb_full  = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.c_rdata <= '0;
            bus.c_ready <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_rd    <= 1'b0;
            bus.m_wr    <= 1'b0;
            bus.m_wdata <= '0;
        end else begin
            bus.c_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.c_rd) begin
                        if (hit) begin
                            bus.c_rdata <= hit_data;
                            bus.c_ready <= 1'b1;
                            state       <= RESP;
                        end else begin
                            bus.m_addr <= bus.c_addr;
                            bus.m_rd   <= 1'b1;
                            state      <= MRD;
                        end
                    end else if (accept_wr) begin
                        bus.c_ready <= 1'b1;
                        state       <= RESP;
                    end else if (count != '0) begin
                        bus.m_addr  <= head_addr;
                        bus.m_wdata <= head_data;
                        bus.m_wr    <= 1'b1;
                        state       <= MWR;
                    end
                end
                MRD: begin
                    if (bus.m_ready) begin
                        bus.c_rdata <= bus.m_rdata;
                        bus.m_rd    <= 1'b0;
                        bus.c_ready <= 1'b1;
                        state       <= RESP;
                    end
                end
                MWR: begin
                    if (bus.m_ready) begin
                        bus.m_wr <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.c_rd && bus.c_wr));

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: vector table, corner sequences and a random run against a queue model.
module tb_write_buffer;
    import wbuf_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef WBUF_COALESCE_EN
    localparam int DUP = 0;
`else
    localparam int DUP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    write_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending posted writes in acceptance order, plus memory contents.
    wbuf_entry_t      pending[$];
    logic [DW-1:0]    mem [logic [AW-1:0]];
    bit               mem_en   = 1'b0;
    int               mem_lat  = 0;
    int               wait_cnt = 0;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
        int            exp_count;
        bit            exp_mrd;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] a);
        for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].addr == a) return pending[i].data;
        end
        return mem_val(a);
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wbuf_entry_t e;
`ifdef WBUF_COALESCE_EN
        for (int i = 0; i < pending.size(); i++) begin
            if (pending[i].addr == a) begin
                pending[i].data = d;
                return;
            end
        end
`endif
        e.valid = 1'b1;
        e.addr  = a;
        e.data  = d;
        pending.push_back(e);
    endfunction

    // Memory responder: answers after mem_lat extra cycles; every drained write must match the model head.
    always @(negedge clk) begin
        bus.m_ready = 1'b0;
        if (!rst && mem_en && (bus.m_rd || bus.m_wr)) begin
            if (wait_cnt >= mem_lat) begin
                bus.m_ready = 1'b1;
                wait_cnt    = 0;
                if (bus.m_rd) begin
                    bus.m_rdata = mem_val(bus.m_addr);
                end else begin
                    if (pending.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL drain_unexpected: got write to %0h, expected none", bus.m_addr);
                    end else begin
                        check("drain_addr", bus.m_addr, pending[0].addr);
                        check("drain_data", bus.m_wdata, pending[0].data);
                        void'(pending.pop_front());
                    end
                    mem[bus.m_addr] = bus.m_wdata;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // cyc numbers the cycle in which the request is presented as 1.
    task automatic do_op(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rdata, output int cyc, output bit saw_mrd);
        bit ok = 1'b0;
        bus.c_addr  = a;
        bus.c_wdata = d;
        bus.c_wr    = is_wr;
        bus.c_rd    = !is_wr;
        cyc     = 1;
        saw_mrd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.m_rd) saw_mrd = 1'b1;
            if (bus.c_ready) begin
                ok = 1'b1;
                break;
            end
        end
        rdata    = bus.c_rdata;
        bus.c_rd = 1'b0;
        bus.c_wr = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL op_timeout: got no c_ready for addr %0h, expected c_ready", a);
        end else if (is_wr) begin
            model_write(a, d);
        end
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.wb_count == 0 && !bus.m_wr) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_drained"}, done, 1);
        check({tag, "_model_empty"}, pending.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int            cyc;
        bit            mrd;
        bit            got;

        // Row latencies are for an idle FSM; rows after the first follow a RESP cycle and add one.
        tbl[0] = '{1'b1, 32'h10, 32'h5555_0010, 32'h0,          2, 1,       1'b0};
        tbl[1] = '{1'b1, 32'h20, 32'h0000_1234, 32'h0,          2, 2,       1'b0};
        tbl[2] = '{1'b0, 32'h20, 32'h0,         32'h0000_1234,  2, 2,       1'b0};
        tbl[3] = '{1'b0, 32'h40, 32'h0,         32'h0000_BEEF,  5, 2,       1'b1};
        tbl[4] = '{1'b1, 32'h08, 32'h0000_0001, 32'h0,          2, 3,       1'b0};
        tbl[5] = '{1'b1, 32'h08, 32'h0000_0002, 32'h0,          2, 3 + DUP, 1'b0};
        tbl[6] = '{1'b0, 32'h08, 32'h0,         32'h0000_0002,  2, 3 + DUP, 1'b0};
        tbl[7] = '{1'b0, 32'h10, 32'h0,         32'h5555_0010,  2, 3 + DUP, 1'b0};

        bus.c_addr  = '0;
        bus.c_wdata = '0;
        bus.c_rd    = 1'b0;
        bus.c_wr    = 1'b0;
        mem[32'h40] = 32'h0000_BEEF;

        #1 rst = 1'b1;
        #2;
        check("rst_c_ready", bus.c_ready, 0);
        check("rst_c_rdata", bus.c_rdata, 0);
        check("rst_m_rd", bus.m_rd, 0);
        check("rst_m_wr", bus.m_wr, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_count", bus.wb_count, 0);
        check("rst_full", bus.wb_full, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single posted write with memory stalled, then the background drain.
        mem_en  = 1'b0;
        mem_lat = 1;
        do_op(1'b1, 32'h10, 32'hAAAA_0001, rd, cyc, mrd);
        check("w1_latency", cyc, 2);
        check("w1_count", bus.wb_count, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("w1_m_wr", bus.m_wr, 1);
        check("w1_m_addr", bus.m_addr, 32'h10);
        check("w1_m_wdata", bus.m_wdata, 32'hAAAA_0001);
        mem_en = 1'b1;
        wait_drain("w1");

        mem_lat = 2;
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].is_wr, tbl[i].addr, tbl[i].data, rd, cyc, mrd);
            if (!tbl[i].is_wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), cyc, tbl[i].exp_lat + ((i > 0) ? 1 : 0));
            check($sformatf("vec%0d_count", i), bus.wb_count, tbl[i].exp_count);
            check($sformatf("vec%0d_full", i), bus.wb_full, (tbl[i].exp_count == DEPTH));
            check($sformatf("vec%0d_m_rd", i), mrd, tbl[i].exp_mrd);
        end
        wait_drain("vec");
        check("vec_mem8", mem_val(32'h8), 32'h2);

        // Fill the buffer with memory stalled; a fifth write must wait for one drain.
        mem_en  = 1'b0;
        mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, AW'(i), DW'(32'h100 + i), rd, cyc, mrd);
        end
        check("fill_count", bus.wb_count, 4);
        check("fill_full", bus.wb_full, 1);
        bus.c_addr  = 32'h4;
        bus.c_wdata = 32'h104;
        bus.c_wr    = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.c_ready) got = 1'b1;
        end
        check("full_stall_ready", got, 0);
        check("full_drain_m_wr", bus.m_wr, 1);
        check("full_drain_addr", bus.m_addr, 32'h0);
        mem_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.c_ready) begin
                got = 1'b1;
                break;
            end
        end
        bus.c_wr = 1'b0;
        check("full_accept", got, 1);
        if (got) model_write(32'h4, 32'h104);
        check("full_count_after", bus.wb_count, 4);
        wait_drain("full");

        // Asynchronous reset while a drain is outstanding.
        mem_en = 1'b0;
        do_op(1'b1, 32'h30, 32'h77, rd, cyc, mrd);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_wr) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_mwr_reached", got, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_m_wr", bus.m_wr, 0);
        check("rst_mid_count", bus.wb_count, 0);
        check("rst_mid_c_ready", bus.c_ready, 0);
        pending.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        mem_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.m_wr) got = 1'b1;
        end
        check("rst_no_drain", got, 0);
        do_op(1'b0, 32'h30, 32'h0, rd, cyc, mrd);
        check("rst_read_rdata", rd, mem_val(32'h30));
        check("rst_read_m_rd", mrd, 1);

        // Random traffic over a small address set.
        for (int n = 0; n < 150; n++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [DW-1:0] exp;
            bit            w;
            int            gap;
            gap     = $urandom_range(0, 2);
            mem_lat = $urandom_range(0, 3);
            a       = AW'($urandom_range(0, 7));
            d       = $urandom;
            w       = 1'($urandom_range(0, 1));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            exp = expect_read(a);
            do_op(w, a, d, rd, cyc, mrd);
            if (!w) check($sformatf("rnd%0d_rdata", n), rd, exp);
            check($sformatf("rnd%0d_count", n), bus.wb_count, pending.size());
            check($sformatf("rnd%0d_full", n), bus.wb_full, (pending.size() == DEPTH));
        end
        wait_drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write buffer between the cache's memory-side port and backing memory.
- Cache writes (write-through stores, dirty evictions) are queued in a FIFO and acknowledged quickly; the FIFO drains to memory in the background.
- Cache reads are forwarded from the buffer on an address match; otherwise they go to memory ahead of pending drains.

Parameters:
- ADDR_WIDTH, 32, address width (word address, matching the cache)
- DATA_WIDTH, 32, data word width
- DEPTH, 4, buffer entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- c_addr  in  ADDR_WIDTH  cache request address
- c_rd  in  1  cache read request (level, held until c_ready)
- c_wr  in  1  cache write request (level, held until c_ready)
- c_wdata  in  DATA_WIDTH  cache write data
- c_rdata  out  DATA_WIDTH  read data, valid while c_ready=1
- c_ready  out  1  one-cycle completion pulse
- m_addr  out  ADDR_WIDTH  memory address
- m_rd  out  1  memory read (held until m_ready)
- m_wr  out  1  memory write (held until m_ready)
- m_wdata  out  DATA_WIDTH  memory write data
- m_rdata  in  DATA_WIDTH  memory read data, sampled when m_ready=1
- m_ready  in  1  memory completion, one cycle
- wb_count  out  $clog2(DEPTH)+1  occupied entries
- wb_full  out  1  wb_count==DEPTH

Behaviour:
- Reset (async, immediate): all outputs 0; FSM=IDLE; entries invalidated; wr/rd pointers and count 0.
- Reset mid-transaction drops m_rd/m_wr at once and discards all buffered writes.
- FSM states: IDLE, MRD, MWR, RESP. Requests are examined only in IDLE.
- IDLE priority, evaluated each cycle:
  - 1. c_rd=1, forward hit: load c_rdata with the youngest matching entry's data; go to RESP.
  - 1. c_rd=1, no hit: m_addr<=c_addr, m_rd<=1; go to MRD.
  - 2. c_wr=1 and !wb_full: enqueue {c_addr,c_wdata} at the tail; go to RESP.
  - 3. wb_count!=0: m_addr/m_wdata<=head entry, m_wr<=1; go to MWR.
  - Otherwise stay in IDLE.
- A write that arrives while the buffer is full falls through to rule 3, so the buffer drains first and the write is accepted on a later IDLE visit.
- MRD: hold m_rd/m_addr. On m_ready: c_rdata<=m_rdata, m_rd<=0, go to RESP.
- MWR: hold m_wr/m_addr/m_wdata. On m_ready: pop head, m_wr<=0, go to IDLE.
- RESP: c_ready=1 for exactly one cycle, then IDLE. Requests are ignored during RESP; the cache deasserts on c_ready.
- Latency:
  - buffered write: c_ready 2 cycles after c_wr is seen in IDLE
  - forwarded read: 2 cycles
  - memory read: memory latency + 2
- c_rd and c_wr together is a protocol error: the read wins and the write is ignored (SVA flags it).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is incremented on enqueue and decremented on pop; both never occur in the same cycle.
- m_ready outside MRD/MWR is ignored.
- c_rdata holds its last value outside RESP.
- Forward match compares the full ADDR_WIDTH over valid entries only; the youngest entry (closest to tail) wins.

Optional Feature:
- Macro WBUF_COALESCE_EN.
- Defined: a write whose address matches a valid entry overwrites that entry's data in place. Count is unchanged, it is accepted even when full, and it completes via RESP. At most one entry per address.
- Undefined: every write enqueues a new entry; duplicates are allowed and forwarding picks the youngest.

Decomposition:
- Package wbuf_pkg:
  - wbuf_state_e enum (IDLE, MRD, MWR, RESP)
  - wbuf_entry_t struct {valid, addr, data}, parameterised via localparams matching defaults
- Sub-module wbuf_entry_array:
  - entry storage, head/tail pointers, count, full
  - combinational address match returning hit, youngest index and data
  - top level keeps the FSM and port muxing

Test Plan:
- Write 0x10<-0xAAAA_0001 with m_ready held low -> c_ready 2 cycles later, wb_count=1, m_wr asserted with m_addr=0x10 on the next IDLE cycle.
- Write 0x20<-0x1234, then read 0x20 before the drain -> c_rdata=0x1234 in 2 cycles, no m_rd pulse.
- Read 0x40 with buffer empty and memory answering 0xBEEF after 3 cycles -> c_ready at cycle 5, c_rdata=0xBEEF.
- Fill 4 writes (0x0..0x3) with m_ready low, then a 5th write to 0x4 -> no c_ready until the first m_ready pops 0x0; then 0x4 is accepted and wb_count returns to 4.
- WBUF_COALESCE_EN: write 0x8<-1 then 0x8<-2 -> wb_count=1, one drain of data 2. Undefined: wb_count=2, read of 0x8 forwards 2, drains in order 1 then 2.
- Assert rst while in MWR -> m_wr=0 same cycle, wb_count=0, FSM=IDLE; no drain after release.
